// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BCD_NIB_W = 4;

  // Decimal digits needed to show the largest bin_w-bit unsigned value.
  function automatic int min_digits(input int bin_w);
    longint unsigned v;
    int n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 0;
    for (int i = 0; i < 21; i++) begin
      if (v != 64'd0) begin
        n = n + 1;
        v = v / 64'd10;
      end
    end
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_NIB_W-1:0] d,
  output logic [BCD_NIB_W-1:0] q
);

  // Add-3 correction; a legal digit (0..9) never overflows the nibble.
  always_comb begin
    q = d;
    if (d >= BCD_NIB_W'(5)) q = d + BCD_NIB_W'(3);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock,
// valid/ready on both sides.
// Optional build macro BIN2BCD_SIGNED_EN: two's complement input, magnitude
// is converted and the sign is reported on out_neg.
//
// state | meaning
// IDLE  | in_ready high, waiting for an input
// SHIFT | one adjust+shift step per clock, BIN_W steps in total
// DONE  | out_valid high, result held until out_ready
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              in_bin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_NIB_W*DIGITS-1:0]   out_bcd
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                          out_neg
`endif
);

  localparam int ACC_W = BCD_NIB_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam int LAST  = BIN_W - 1;

  if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
    $error("bin2bcd_seq: BIN_W must be in 4..32");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_adj, acc_shift;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [ACC_W-1:0]   out_bcd_q, out_bcd_d;
  logic [BIN_W-1:0]   load_val;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (acc_q[g*BCD_NIB_W +: BCD_NIB_W]),
      .q (acc_adj[g*BCD_NIB_W +: BCD_NIB_W])
    );
  end

  assign acc_shift = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};

`ifdef BIN2BCD_SIGNED_EN
  logic neg_q, neg_d;
  // Magnitude of a two's complement input; the most-negative value maps
  // to 2^(BIN_W-1), which still fits unsigned in BIN_W bits.
  assign load_val = in_bin[BIN_W-1] ? (~in_bin + BIN_W'(1)) : in_bin;
  assign out_neg  = neg_q;
`else
  assign load_val = in_bin;
`endif

  // Next-state, datapath step and output register updates.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
`ifdef BIN2BCD_SIGNED_EN
    neg_d       = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          bin_d   = load_val;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef BIN2BCD_SIGNED_EN
          neg_d   = in_bin[BIN_W-1];
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = bin_q << 1;
        acc_d = acc_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST)) begin
          out_bcd_d   = acc_shift;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_bcd_q   <= '0;
`ifdef BIN2BCD_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_bcd_q   <= out_bcd_d;
`ifdef BIN2BCD_SIGNED_EN
      neg_q       <= neg_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (BIN_W=16, DIGITS=5). Expected results
// come from a decimal reference model using integer division.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [BIN_W-1:0]  in_bin = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [4*DIGITS-1:0] out_bcd;
`ifdef BIN2BCD_SIGNED_EN
  logic              out_neg;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd)
`ifdef BIN2BCD_SIGNED_EN
    ,
    .out_neg   (out_neg)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: magnitude of the input as the converter should see it.
  function automatic int model_mag(input logic [BIN_W-1:0] v);
`ifdef BIN2BCD_SIGNED_EN
    if (v[BIN_W-1]) return (1 << BIN_W) - int'(v);
`endif
    return int'(v);
  endfunction

  function automatic logic model_neg(input logic [BIN_W-1:0] v);
`ifdef BIN2BCD_SIGNED_EN
    return v[BIN_W-1];
`else
    return 1'b0;
`endif
  endfunction

  // Reference: decimal digits by repeated division.
  function automatic logic [4*DIGITS-1:0] model_bcd(input int m);
    logic [4*DIGITS-1:0] r;
    int x;
    r = '0;
    x = m;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Presents v until accepted; returns with the accept edge just passed.
  task automatic send(input logic [BIN_W-1:0] v);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_bin   = v;
    for (int n = 0; n < 60; n++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready never high for input %0d", v);
    end
  endtask

  // Cycles from now until out_valid is seen (-1 if it never comes).
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_bcd !== '0) begin n_bad++; $display("FAIL reset_out_bcd: got %h want 0", out_bcd); end
`ifdef BIN2BCD_SIGNED_EN
    n_cmp++; if (out_neg !== 1'b0) begin n_bad++; $display("FAIL reset_out_neg: got %b want 0", out_neg); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_zero_timing;
    int lat, e1, e2;
    out_ready = 1'b1;
    send('0);
    e1 = cyc;
    wait_valid(lat);
    n_cmp++; if (lat != BIN_W) begin n_bad++; $display("FAIL zero_latency: got %0d want %0d", lat, BIN_W); end
    n_cmp++; if (out_bcd !== 20'h00000) begin n_bad++; $display("FAIL zero_value: got %h want 00000", out_bcd); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_bad++; $display("FAIL zero_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    send(16'd5);
    e2 = cyc;
    n_cmp++; if (e2 - e1 != BIN_W + 2) begin n_bad++; $display("FAIL accept_period: got %0d want %0d", e2 - e1, BIN_W + 2); end
    wait_valid(lat);
    n_cmp++; if (out_bcd !== model_bcd(5)) begin n_bad++; $display("FAIL five_value: got %h want %h", out_bcd, model_bcd(5)); end
    @(posedge clk); #1;
  endtask

  task automatic test_values;
    logic [BIN_W-1:0] v;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      case (i)
        0: v = 16'd65535;
        1: v = 16'd12345;
        2: v = 16'd9;
        3: v = 16'd10;
        default: v = BIN_W'($urandom);
      endcase
      send(v);
      wait_valid(lat);
      n_cmp++; if (lat != BIN_W) begin n_bad++; $display("FAIL val_latency[%0d]: got %0d want %0d", i, lat, BIN_W); end
      n_cmp++; if (out_bcd !== model_bcd(model_mag(v)))
        begin n_bad++; $display("FAIL val_bcd[%0d] in=%h: got %h want %h", i, v, out_bcd, model_bcd(model_mag(v))); end
`ifdef BIN2BCD_SIGNED_EN
      n_cmp++; if (out_neg !== model_neg(v))
        begin n_bad++; $display("FAIL val_neg[%0d] in=%h: got %b want %b", i, v, out_neg, model_neg(v)); end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [4*DIGITS-1:0] exp;
    out_ready = 1'b0;
    exp = model_bcd(model_mag(16'd9999));
    send(16'd9999);
    wait_valid(lat);
    n_cmp++; if (lat != BIN_W) begin n_bad++; $display("FAIL bp_latency: got %0d want %0d", lat, BIN_W); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_bcd !== exp || in_ready !== 1'b0)
        begin n_bad++; $display("FAIL bp_hold[%0d]: valid=%b bcd=%h ready=%b want 1/%h/0", k, out_valid, out_bcd, in_ready, exp); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_bad++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_ignore_during_shift;
    logic [BIN_W-1:0] first;
    int seen;
    out_ready = 1'b1;
    first = BIN_W'($urandom);
    in_valid = 1'b1;
    in_bin   = first;
    @(posedge clk); #1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      in_bin = BIN_W'($urandom);
      @(posedge clk); #1;
      if (out_valid) begin seen = 1; break; end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL busy_in_ready[%0d]: got %b want 0", k, in_ready); end
    end
    in_valid = 1'b0;
    n_cmp++; if (seen != 1) begin n_bad++; $display("FAIL ignore_timeout: out_valid got %0d want 1", seen); end
    n_cmp++; if (out_bcd !== model_bcd(model_mag(first)))
      begin n_bad++; $display("FAIL ignore_value: got %h want %h", out_bcd, model_bcd(model_mag(first))); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int stray, lat;
    out_ready = 1'b1;
    send(16'd4321);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL mid_reset_stray: got %0d valid cycles want 0", stray); end
    send(16'd100);
    wait_valid(lat);
    n_cmp++; if (lat != BIN_W) begin n_bad++; $display("FAIL after_reset_latency: got %0d want %0d", lat, BIN_W); end
    n_cmp++; if (out_bcd !== 20'h00100) begin n_bad++; $display("FAIL after_reset_value: got %h want 00100", out_bcd); end
    @(posedge clk); #1;
  endtask

`ifdef BIN2BCD_SIGNED_EN
  task automatic test_signed;
    logic [BIN_W-1:0] v;
    logic [4*DIGITS-1:0] exp_b;
    logic exp_n;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin v = 16'h8000; exp_b = 20'h32768; exp_n = 1'b1; end
        1: begin v = 16'hFFFF; exp_b = 20'h00001; exp_n = 1'b1; end
        default: begin v = 16'd42; exp_b = 20'h00042; exp_n = 1'b0; end
      endcase
      send(v);
      wait_valid(lat);
      n_cmp++; if (out_bcd !== exp_b || out_neg !== exp_n)
        begin n_bad++; $display("FAIL signed[%0d] in=%h: got %h/%b want %h/%b", i, v, out_bcd, out_neg, exp_b, exp_n); end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_timing();
    test_values();
    test_backpressure();
    test_ignore_during_shift();
    test_reset_mid();
`ifdef BIN2BCD_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
